// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared definitions for the uart MMIO controller.
// Holds the register map codes, STATUS/CONTROL bit positions,
// the TX/RX state encodings and a helper that assembles the STATUS word.
package uart_mmio_defs;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_RSVD   = 2'd3;

    localparam int ST_RX_NONEMPTY = 0;
    localparam int ST_RX_FULL     = 1;
    localparam int ST_TX_EMPTY    = 2;
    localparam int ST_TX_FULL     = 3;
    localparam int ST_OVERRUN     = 4;
    localparam int ST_TX_ACTIVE   = 5;

    localparam int CTRL_RX_IE   = 0;
    localparam int CTRL_TX_IE   = 1;
    localparam int CTRL_OVR_CLR = 2;

    typedef enum logic [1:0] {
        T_IDLE  = 2'd0,
        T_WAITB = 2'd1,
        T_WAITD = 2'd2
    } txState_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_CLR  = 1'b1
    } rxState_t;

    function automatic logic [31:0] packStatus(
        input logic rxNonEmpty,
        input logic rxFull,
        input logic txEmpty,
        input logic txFull,
        input logic overrun,
        input logic txActive
    );
        logic [31:0] s;
        s                 = '0;
        s[ST_RX_NONEMPTY] = rxNonEmpty;
        s[ST_RX_FULL]     = rxFull;
        s[ST_TX_EMPTY]    = txEmpty;
        s[ST_TX_FULL]     = txFull;
        s[ST_OVERRUN]     = overrun;
        s[ST_TX_ACTIVE]   = txActive;
        return s;
    endfunction

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// Data-memory bus view of the uart MMIO controller.
// The bus decoder (master) drives address, strobes and write data;
// the peripheral (slave) returns registered read data and its interrupt.
interface uart_mmio_ctrl_if;

    logic [1:0]  addr;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output mem_write,
        output mem_read,
        output wdata,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  mem_write,
        input  mem_read,
        input  wdata,
        output rdata,
        output irq
    );

endinterface

// File: rtl/uart_mmio_ctrl_byte_fifo.sv
// Small byte FIFO used for both the TX and RX paths.
// A pop on a full FIFO frees the slot, so a simultaneous push is accepted;
// a push on a full FIFO without a pop is dropped. The caller decides what
// a dropped push means (silent for TX, overrun for RX).
module byte_fifo
    import uart_mmio_defs::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic       clock_50MHZ,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);

    localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             pushEn;
    logic             popEn;

    assign full   = (count_q == DEPTH_CNT);
    assign empty  = (count_q == '0);
    assign popEn  = pop && !empty;
    assign pushEn = push && (!full || popEn);
    assign dout   = mem_q[rdPtr_q];

    // Next pointer and occupancy values; pointers wrap naturally at the depth.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushEn) begin
            wrPtr_d = wrPtr_q + PTR_ONE;
        end
        if (popEn) begin
            rdPtr_d = rdPtr_q + PTR_ONE;
        end
        if (pushEn && !popEn) begin
            count_d = count_q + CNT_ONE;
        end else if (popEn && !pushEn) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer and count registers; reset empties the FIFO.
    always_ff @(posedge clock_50MHZ or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    // Storage array; contents need no reset since occupancy guards every read.
    always_ff @(posedge clock_50MHZ) begin
        if (pushEn) begin
            mem_q[wrPtr_q] <= din;
        end
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped uart front end for the MIPS32 core.
// CPU writes to DATA are queued and handed to the uart one byte at a time
// with a din/enable handshake gated by tx_busy. Received bytes flagged by
// rdy are captured into an RX FIFO and acknowledged with a rdy_clr pulse.
module uart_mmio_ctrl
    import uart_mmio_defs::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int PTR_W      = 2
) (
    input  logic                  clock_50MHZ,
    input  logic                  reset,
    uart_mmio_ctrl_if.slave       bus,
    output logic [7:0]            uart_din,
    output logic                  uart_enable,
    input  logic                  uart_tx_busy,
    input  logic                  uart_rdy,
    input  logic [7:0]            uart_dout,
    output logic                  uart_rdy_clr
);

    txState_t    txState_q;
    rxState_t    rxState_q;
    logic [7:0]  uartDin_q;
    logic        uartEnable_q;
    logic        rdyClr_q;
    logic        overrun_q;
    logic        rxIe_q;
    logic        txIe_q;
    logic [31:0] rdata_q;
    logic [31:0] readWord_d;

    logic        rdAccess;
    logic        dataWrite;
    logic        dataRead;
    logic        ctrlWrite;

    logic        txPush;
    logic        txPop;
    logic [7:0]  txDout;
    logic        txFull;
    logic        txEmpty;
    logic        txActive;

    logic        rxPush;
    logic        rxPop;
    logic [7:0]  rxDout;
    logic        rxFull;
    logic        rxEmpty;
    logic        rxOverflow;

    logic        unusedWdata;

    assign unusedWdata = ^bus.wdata[31:8];

    assign rdAccess  = bus.mem_read && !bus.mem_write;
    assign dataWrite = bus.mem_write && (bus.addr == ADDR_DATA);
    assign dataRead  = rdAccess && (bus.addr == ADDR_DATA);
    assign ctrlWrite = bus.mem_write && (bus.addr == ADDR_CTRL);

    assign txPush   = dataWrite;
    assign txPop    = (txState_q == T_IDLE) && !txEmpty && !uart_tx_busy;
    assign txActive = (txState_q != T_IDLE);

    assign rxPush     = (rxState_q == R_IDLE) && uart_rdy;
    assign rxPop      = dataRead && !rxEmpty;
    assign rxOverflow = rxPush && rxFull && !rxPop;

    assign uart_din     = uartDin_q;
    assign uart_enable  = uartEnable_q;
    assign uart_rdy_clr = rdyClr_q;
    assign bus.rdata    = rdata_q;
    assign bus.irq      = (rxIe_q && !rxEmpty) || (txIe_q && txEmpty);

    byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) txFifo (
        .clock_50MHZ (clock_50MHZ),
        .reset       (reset),
        .push        (txPush),
        .pop         (txPop),
        .din         (bus.wdata[7:0]),
        .dout        (txDout),
        .full        (txFull),
        .empty       (txEmpty)
    );

    byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .PTR_W      (PTR_W)
    ) rxFifo (
        .clock_50MHZ (clock_50MHZ),
        .reset       (reset),
        .push        (rxPush),
        .pop         (rxPop),
        .din         (uart_dout),
        .dout        (rxDout),
        .full        (rxFull),
        .empty       (rxEmpty)
    );

    // Read-data mux; a combined read+write or an unused address returns zero.
    always_comb begin
        readWord_d = '0;
        if (rdAccess) begin
            case (bus.addr)
                ADDR_DATA:   readWord_d = rxEmpty ? 32'd0 : {24'd0, rxDout};
                ADDR_STATUS: readWord_d = packStatus(!rxEmpty, rxFull, txEmpty,
                                                     txFull, overrun_q, txActive);
                ADDR_CTRL:   readWord_d = {30'd0, txIe_q, rxIe_q};
                ADDR_RSVD:   readWord_d = '0;
                default:     readWord_d = '0;
            endcase
        end
    end

    // Registered read data, presented the cycle after the read strobe.
    always_ff @(posedge clock_50MHZ or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= readWord_d;
        end
    end

    // Interrupt enables and the sticky overrun flag; a new overrun beats a clear.
    always_ff @(posedge clock_50MHZ or posedge reset) begin
        if (reset) begin
            rxIe_q    <= 1'b0;
            txIe_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            if (ctrlWrite) begin
                rxIe_q <= bus.wdata[CTRL_RX_IE];
                txIe_q <= bus.wdata[CTRL_TX_IE];
            end
            if (rxOverflow) begin
                overrun_q <= 1'b1;
            end else if (ctrlWrite && bus.wdata[CTRL_OVR_CLR]) begin
                overrun_q <= 1'b0;
            end
        end
    end

    // TX sequencer: launch one byte, then track the uart's busy rise and fall.
    always_ff @(posedge clock_50MHZ or posedge reset) begin
        if (reset) begin
            txState_q    <= T_IDLE;
            uartDin_q    <= '0;
            uartEnable_q <= 1'b0;
        end else begin
            uartEnable_q <= 1'b0;
            case (txState_q)
                T_IDLE: begin
                    if (txPop) begin
                        uartDin_q    <= txDout;
                        uartEnable_q <= 1'b1;
                        txState_q    <= T_WAITB;
                    end
                end
                T_WAITB: begin
                    if (uart_tx_busy) begin
                        txState_q <= T_WAITD;
                    end
                end
                T_WAITD: begin
                    if (!uart_tx_busy) begin
                        txState_q <= T_IDLE;
                    end
                end
                default: txState_q <= T_IDLE;
            endcase
        end
    end

    // RX sequencer: capture once per rdy, acknowledge, then wait for rdy to drop.
    always_ff @(posedge clock_50MHZ or posedge reset) begin
        if (reset) begin
            rxState_q <= R_IDLE;
            rdyClr_q  <= 1'b0;
        end else begin
            rdyClr_q <= 1'b0;
            case (rxState_q)
                R_IDLE: begin
                    if (uart_rdy) begin
                        rdyClr_q  <= 1'b1;
                        rxState_q <= R_CLR;
                    end
                end
                R_CLR: begin
                    if (!uart_rdy) begin
                        rxState_q <= R_IDLE;
                    end
                end
                default: rxState_q <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl: a bus driver, a 10-cycle tx_busy
// uart model and a simple rdy/dout source, with hand-computed expectations.
module tb_uart_mmio_ctrl;

    import uart_mmio_defs::*;

    logic       clock_50MHZ = 1'b0;
    logic       reset;
    logic [7:0] uart_din;
    logic       uart_enable;
    logic       uart_tx_busy = 1'b0;
    logic       uart_rdy;
    logic [7:0] uart_dout;
    logic       uart_rdy_clr;

    int         compareCount   = 0;
    int         mismatchCount  = 0;
    int         pulseWhileBusy = 0;
    int         clrCount       = 0;
    int         busyCnt        = 0;
    logic       busyHold       = 1'b0;
    logic [7:0] dinLog [$];
    logic [31:0] rd;

    uart_mmio_ctrl_if busIf ();

    uart_mmio_ctrl #(
        .FIFO_DEPTH (4),
        .PTR_W      (2)
    ) dut (
        .clock_50MHZ  (clock_50MHZ),
        .reset        (reset),
        .bus          (busIf),
        .uart_din     (uart_din),
        .uart_enable  (uart_enable),
        .uart_tx_busy (uart_tx_busy),
        .uart_rdy     (uart_rdy),
        .uart_dout    (uart_dout),
        .uart_rdy_clr (uart_rdy_clr)
    );

    always #10 clock_50MHZ = ~clock_50MHZ;

    // uart transmitter model: busy for 10 cycles after each enable pulse.
    always @(posedge clock_50MHZ) begin
        #1;
        if (uart_enable) begin
            if (uart_tx_busy) pulseWhileBusy++;
            dinLog.push_back(uart_din);
            busyCnt = 10;
        end else if (busyCnt > 0) begin
            busyCnt--;
        end
        uart_tx_busy = busyHold || (busyCnt > 0);
    end

    // Counts rdy_clr pulses seen by the uart receiver.
    always @(posedge clock_50MHZ) begin
        #1;
        if (uart_rdy_clr) clrCount++;
    end

    // Watchdog so the run always ends.
    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock_50MHZ);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic wr, input logic rdStrobe, input logic [1:0] a,
                                 input logic [31:0] d, output logic [31:0] readBack);
        @(posedge clock_50MHZ);
        #1;
        busIf.addr      = a;
        busIf.mem_write = wr;
        busIf.mem_read  = rdStrobe;
        busIf.wdata     = d;
        @(posedge clock_50MHZ);
        #1;
        busIf.mem_write = 1'b0;
        busIf.mem_read  = 1'b0;
        readBack        = busIf.rdata;
    endtask

    task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        applyStimulus(1'b1, 1'b0, a, d, dummy);
    endtask

    task automatic busRead(input logic [1:0] a, output logic [31:0] d);
        applyStimulus(1'b0, 1'b1, a, 32'd0, d);
    endtask

    task automatic waitPulses(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && dinLog.size() < n; i++) idle(1);
        checkOutput(tag, dinLog.size(), n);
    endtask

    task automatic waitTxQuiet(input int budget);
        for (int i = 0; i < budget && uart_tx_busy; i++) idle(1);
        if (uart_tx_busy) checkOutput("tx_busy_timeout", 1, 0);
        idle(2);
    endtask

    task automatic rxByte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        @(posedge clock_50MHZ);
        #1;
        uart_rdy  = 1'b1;
        uart_dout = b;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock_50MHZ);
            #1;
            if (uart_rdy_clr) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) checkOutput("rx_clr_timeout", 0, 1);
        idle(1);
        uart_rdy = 1'b0;
        idle(1);
    endtask

    initial begin
        reset           = 1'b1;
        busIf.addr      = 2'd0;
        busIf.mem_write = 1'b0;
        busIf.mem_read  = 1'b0;
        busIf.wdata     = 32'd0;
        uart_rdy        = 1'b0;
        uart_dout       = 8'd0;

        idle(3);
        checkOutput("por_rdata", busIf.rdata, 32'd0);
        checkOutput("por_irq", busIf.irq, 0);
        checkOutput("por_din", uart_din, 0);
        checkOutput("por_enable", uart_enable, 0);
        checkOutput("por_rdy_clr", uart_rdy_clr, 0);
        reset = 1'b0;
        idle(1);
        busRead(ADDR_STATUS, rd);
        checkOutput("por_status", rd, 32'h04);

        busWrite(ADDR_CTRL, 32'h2);
        checkOutput("t1_irq_txie", busIf.irq, 1);
        busWrite(ADDR_DATA, 32'h55);
        waitPulses(1, 20, "t1_pulse_count");
        checkOutput("t1_din", uart_din, 32'h55);
        busRead(ADDR_STATUS, rd);
        checkOutput("t1_status_active", rd, 32'h24);
        #4;
        reset = 1'b1;
        #1;
        checkOutput("t1_rst_rdata", busIf.rdata, 32'd0);
        checkOutput("t1_rst_irq", busIf.irq, 0);
        checkOutput("t1_rst_din", uart_din, 0);
        checkOutput("t1_rst_enable", uart_enable, 0);
        checkOutput("t1_rst_rdy_clr", uart_rdy_clr, 0);
        @(posedge clock_50MHZ);
        #1;
        reset = 1'b0;
        waitTxQuiet(30);
        busRead(ADDR_STATUS, rd);
        checkOutput("t1_status_after_rst", rd, 32'h04);
        busRead(ADDR_CTRL, rd);
        checkOutput("t1_ctrl_after_rst", rd, 32'h0);

        dinLog.delete();
        pulseWhileBusy = 0;
        busWrite(ADDR_DATA, 32'h41);
        busWrite(ADDR_DATA, 32'h42);
        busWrite(ADDR_DATA, 32'h43);
        waitPulses(3, 200, "t2_pulse_count");
        waitTxQuiet(40);
        for (int i = 0; i < 3; i++)
            checkOutput($sformatf("t2_din%0d", i),
                        (i < dinLog.size()) ? {24'd0, dinLog[i]} : 32'hDEAD,
                        32'h41 + i);
        checkOutput("t2_pulse_while_busy", pulseWhileBusy, 0);
        busRead(ADDR_STATUS, rd);
        checkOutput("t2_status_empty", rd, 32'h04);

        dinLog.delete();
        busyHold = 1'b1;
        idle(2);
        for (int i = 0; i < 4; i++) busWrite(ADDR_DATA, 32'h61 + i);
        busRead(ADDR_STATUS, rd);
        checkOutput("t3_status_full4", rd, 32'h08);
        busWrite(ADDR_DATA, 32'h65);
        busRead(ADDR_STATUS, rd);
        checkOutput("t3_status_full5", rd, 32'h08);
        busyHold = 1'b0;
        waitPulses(4, 200, "t3_pulse_count");
        waitTxQuiet(40);
        idle(5);
        checkOutput("t3_no_fifth", dinLog.size(), 4);
        for (int i = 0; i < 4; i++)
            checkOutput($sformatf("t3_din%0d", i),
                        (i < dinLog.size()) ? {24'd0, dinLog[i]} : 32'hDEAD,
                        32'h61 + i);
        checkOutput("t3_pulse_while_busy", pulseWhileBusy, 0);
        busRead(ADDR_STATUS, rd);
        checkOutput("t3_status_empty", rd, 32'h04);

        clrCount = 0;
        rxByte(8'h5A);
        idle(2);
        checkOutput("t4_clr_count", clrCount, 1);
        busRead(ADDR_STATUS, rd);
        checkOutput("t4_status_rx", rd, 32'h05);
        busRead(ADDR_DATA, rd);
        checkOutput("t4_data", rd, 32'h5A);
        busRead(ADDR_STATUS, rd);
        checkOutput("t4_status_after", rd, 32'h04);

        for (int i = 0; i < 4; i++) rxByte(8'h11 + 8'(i));
        busRead(ADDR_STATUS, rd);
        checkOutput("t5_status_full", rd, 32'h07);
        rxByte(8'h15);
        busRead(ADDR_STATUS, rd);
        checkOutput("t5_status_overrun", rd, 32'h17);
        for (int i = 0; i < 4; i++) begin
            busRead(ADDR_DATA, rd);
            checkOutput($sformatf("t5_data%0d", i), rd, 32'h11 + i);
        end
        busRead(ADDR_DATA, rd);
        checkOutput("t5_data_empty", rd, 32'h0);
        busRead(ADDR_STATUS, rd);
        checkOutput("t5_status_drained", rd, 32'h14);
        busWrite(ADDR_CTRL, 32'h4);
        busRead(ADDR_STATUS, rd);
        checkOutput("t5_status_cleared", rd, 32'h04);

        busWrite(ADDR_CTRL, 32'h1);
        checkOutput("t6_irq_idle", busIf.irq, 0);
        rxByte(8'h77);
        checkOutput("t6_irq_rx", busIf.irq, 1);
        busRead(ADDR_DATA, rd);
        checkOutput("t6_data", rd, 32'h77);
        checkOutput("t6_irq_after_read", busIf.irq, 0);
        busWrite(ADDR_CTRL, 32'h2);
        checkOutput("t6_irq_tx", busIf.irq, 1);

        applyStimulus(1'b1, 1'b1, ADDR_CTRL, 32'h3, rd);
        checkOutput("rw_same_rdata", rd, 32'h0);
        busRead(ADDR_CTRL, rd);
        checkOutput("rw_same_ctrl", rd, 32'h3);
        busWrite(ADDR_RSVD, 32'hFF);
        busRead(ADDR_RSVD, rd);
        checkOutput("rsvd_read", rd, 32'h0);
        busRead(ADDR_STATUS, rd);
        checkOutput("rsvd_status", rd, 32'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
